// File: rtl/uncache_bridge.sv
// rtl/uncache_bridge.sv - single-outstanding uncached request to AXI4 single-beat bridge
module uncache_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uncache_valid,
    input  logic        uncache_op,
    input  logic [31:0] uncache_addr,
    input  logic [1:0]  uncache_size,
    input  logic [3:0]  uncache_wstrb,
    input  logic [31:0] uncache_wdata,
    output logic        uncache_addr_ok,
    output logic        uncache_data_ok,
    output logic [31:0] uncache_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;

    // Responses are not error-checked: every transaction completes normally.
    logic        resp_unused;
    assign resp_unused = ^{rresp, bresp};

    assign uncache_addr_ok = uncache_valid & (state == IDLE);
    assign aw_hs           = awvalid & awready;
    assign w_hs            = wvalid & wready;

    assign arid   = AXI_ID;
    assign awid   = AXI_ID;
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            addr_q          <= 32'd0;
            wdata_q         <= 32'd0;
            size_q          <= 2'd0;
            wstrb_q         <= 4'd0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            awvalid         <= 1'b0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
            uncache_data_ok <= 1'b0;
            uncache_rdata   <= 32'd0;
        end else begin
            uncache_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (uncache_valid) begin
                        addr_q  <= uncache_addr;
                        size_q  <= uncache_size;
                        wstrb_q <= uncache_wstrb;
                        wdata_q <= uncache_wdata;
                        if (uncache_op) begin
                            state   <= WR_AW_W;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state   <= RD_AR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready          <= 1'b0;
                        uncache_rdata   <= rdata;
                        uncache_data_ok <= 1'b1;
                        state           <= IDLE;
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // AW and W may finish in either order or together.
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready          <= 1'b0;
                        uncache_data_ok <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uncache_bridge.md
# uncache_bridge

Single-outstanding uncached access responder for the MEM1 stage. It presents the pipeline-side `valid`/`addr_ok`/`data_ok` handshake that the hazard/stall unit consumes. It converts each accepted request into one AXI4 single-beat read (AR/R) or write (AW/W/B) transaction. It sits between the MEM1 uncache port and the AXI crossbar. The crossbar ties `len=0`, `burst=INCR` and `wlast=1`.

## Interface
- `AXI_ID`, default 4'd1, constant driven on `arid`/`awid`.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `uncache_valid` input 1: request present.
- `uncache_op` input 1: 1 = write, 0 = read.
- `uncache_addr` input 32: byte address.
- `uncache_size` input 2: 0 = byte, 1 = half, 2 = word.
- `uncache_wstrb` input 4: write byte strobes.
- `uncache_wdata` input 32: write data.
- `uncache_addr_ok` output 1: request accepted this cycle.
- `uncache_data_ok` output 1: one-cycle completion pulse.
- `uncache_rdata` output 32: read data, valid while `data_ok`=1.
- `arid` output 4, `araddr` output 32, `arsize` output 3, `arvalid` output 1, `arready` input 1.
- `rdata` input 32, `rresp` input 2, `rvalid` input 1, `rready` output 1.
- `awid` output 4, `awaddr` output 32, `awsize` output 3, `awvalid` output 1, `awready` input 1.
- `wdata` output 32, `wstrb` output 4, `wvalid` output 1, `wready` input 1.
- `bresp` input 2, `bvalid` input 1, `bready` output 1.

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B. Reset state is IDLE.
- `addr_ok` = `uncache_valid` & (state==IDLE). It is combinational and is the only combinational path from inputs to outputs.
- On acceptance (`valid` & `addr_ok`), register addr, size, wstrb and wdata.
  - Read: go to RD_AR.
  - Write: go to WR_AW_W and clear `aw_done` and `w_done`.
- RD_AR:
  - `arvalid`=1 with the latched address; `arsize` = {1'b0, size}.
  - On `arready`, go to RD_R.
- RD_R:
  - `rready`=1.
  - On `rvalid`, register `rdata` into `uncache_rdata`, set `data_ok` for the next cycle, and go to IDLE.
- WR_AW_W:
  - `awvalid` = !`aw_done`; `wvalid` = !`w_done`.
  - Each channel handshakes independently; set its done flag on its handshake.
  - Leave for WR_B at the edge where both channels have completed, whether in the same cycle or in different cycles.
- WR_B:
  - `bready`=1.
  - On `bvalid`, set `data_ok` for the next cycle and go to IDLE.
- `data_ok` is a registered one-cycle pulse for both reads and writes. The stall unit ignores it for writes; the bridge still blocks new requests until B returns, which keeps uncached ordering strict.
- `rresp`/`bresp` are ignored. The transaction completes normally on any response.
- AXI outputs stay stable while valid is high and ready is low.
- `uncache_rdata` holds its last value until the next read completes.
- There is no cancel input. The pipeline never withdraws an accepted request.

## Timing
- Reset values:
  - State IDLE.
  - `arvalid`, `rready`, `awvalid`, `wvalid`, `bready`, `data_ok` = 0.
  - `uncache_rdata` = 0; the latched address, strobes and data = 0.
  - `addr_ok` = 0 unless `valid`=1 while in IDLE.
- Read, minimum latency with `arready`=1 and `rvalid` in the cycle after AR: accept at cycle 0, `arvalid` at cycle 1, R handshake at cycle 2, `data_ok` at cycle 3.
- Write, minimum latency: accept at cycle 0, AW and W at cycle 1, B at cycle 2, `data_ok` at cycle 3.
- Back-to-back: in the `data_ok` cycle the state is already IDLE, so `addr_ok` may assert in that same cycle.
- Reset asserted mid-transaction: all valid and ready outputs drop immediately. The in-flight transaction is abandoned; the system resets the crossbar together with the bridge.

## Test plan
- Read 0x1FE001E0 size 2, `arready`=1, `rvalid` with `rdata`=0xDEADBEEF at cycle 2 -> `arvalid` at cycle 1 with `araddr`=0x1FE001E0 and `arsize`=2; `data_ok`=1 at cycle 3 with `uncache_rdata`=0xDEADBEEF; exactly one pulse.
- Write 0x1FE001E4, `wstrb`=4'b0011, `wdata`=0x1234; `awready` delayed 3 cycles, `wready` immediate -> `wvalid` low after 1 cycle; `awvalid` held 3 cycles with stable address; `bready` only after both handshakes; `data_ok` one cycle after `bvalid`.
- `uncache_valid` held high across two reads -> second `addr_ok` coincides with the first `data_ok`; no `addr_ok` while busy.
- `arready` held 0 for 10 cycles -> `arvalid` and `araddr` stable throughout; `addr_ok` stays 0 for a new request.
- `resetn` pulled low during RD_R -> all AXI valid/ready outputs and `data_ok` at 0 asynchronously; after release, a new read completes normally.
- `rresp`=2'b10 on a read -> `data_ok` still pulses with the returned data.
